axis_req_ack_32bit_sender: RTL and testbench
============================================

Name: axis_req_ack_32bit_sender

Overview:
- Host-to-chip transmit path: accepts 64-bit AXI-Stream frames from the DMA side.
- Serialises each beat into two 32-bit words, high word first.
- Delivers each word to PAICORE over the four-phase request/acknowledge interface.
- Counterpart of the PAICORE receive path; reports busy, done, frame count and handshake timeout to the control registers.

Parameters:
- SYNC_STAGES, 2: flip-flop stages synchronising acknowledge; legal range 2..4.
- TIMEOUT_CYCLES, 65535: cycles allowed in REQ or RELEASE before error; 0 disables the timeout.
- CNT_W, 32: width of o_frame_cnt.

Ports:
- s_axis_aclk  in  1  single clock for the block.
- s_axis_areset  in  1  synchronous reset, active-high.
- s_axis_tvalid  in  1  AXIS beat valid.
- s_axis_tdata  in  64  AXIS beat; [63:32] is sent first, then [31:0].
- s_axis_tlast  in  1  last beat of the frame.
- s_axis_tready  out  1  AXIS ready.
- s_axis_hsked  out  1  one-cycle pulse on tvalid&&tready.
- dout  out  32  word presented to PAICORE.
- request  out  1  four-phase request.
- acknowledge  in  1  four-phase acknowledge from PAICORE, asynchronous.
- i_clr_err  in  1  clears o_tx_error and leaves ERROR.
- o_tx_busy  out  1  high whenever state != IDLE.
- o_tx_done  out  1  one-cycle pulse after the tlast beat's low word completes.
- o_tx_error  out  1  sticky timeout flag.
- o_frame_cnt  out  CNT_W  count of 64-bit beats fully sent; wraps modulo 2^CNT_W.

Behaviour:
- Reset values: tready=0, hsked=0, dout=0, request=0, busy=0, done=0, error=0, frame_cnt=0.
- Reset empties the synchroniser, word_sel and the timeout counter.
- Reset asserted mid-handshake drops request to 0 the next cycle and discards the held beat.
- acknowledge passes through SYNC_STAGES flops to form ack_s; all decisions use ack_s.
- tready is registered: it is 1 only in IDLE while ack_s==0, so there is no overlap with a stale acknowledge.
- IDLE:
  - On tvalid&&tready, latch tdata and tlast, pulse hsked, clear word_sel, go to SETUP.
  - tready drops the following cycle.
- SETUP:
  - dout = word_sel ? data[31:0] : data[63:32]; request=0.
  - Lasts exactly one cycle (data setup before request), then REQ.
- REQ:
  - request=1, dout held.
  - ack_s==1 -> RELEASE.
- RELEASE:
  - request=0, dout held.
  - ack_s==0 with word_sel==0 -> word_sel=1, go to SETUP.
  - ack_s==0 with word_sel==1 -> frame_cnt+1, pulse done if the latched tlast is set, go to IDLE.
- Throughput: one beat needs at least 2×(1 + 1 + SYNC_STAGES + handshake turnaround) cycles.
- Timeout:
  - The counter clears on every entry to REQ or RELEASE and increments while in either state.
  - If TIMEOUT_CYCLES!=0 and the counter equals TIMEOUT_CYCLES, go to ERROR.
- ERROR:
  - request=0, tready=0, busy=1, error=1; the current beat is discarded.
  - i_clr_err -> error=0, go to IDLE. IDLE still waits for ack_s==0 before raising tready.
- Simultaneous events:
  - i_clr_err outside ERROR is ignored.
  - done and the next IDLE acceptance cannot coincide, because tready is registered.
- request is a registered output, glitch-free; dout changes only in SETUP.

Decomposition:
- Shared package paicore_tx_pkg holds:
  - state enum: IDLE, SETUP, REQ, RELEASE, ERROR;
  - constant WORD_W=32;
  - constant BEAT_W=64.
- Sub-module sync_ff: parameterised SYNC_STAGES bit synchroniser, reusable by the receive side.

Test Plan:
- Single beat 64'hDEAD_BEEF_0123_4567 with tlast=1, responder acks 3 cycles after request -> dout 32'hDEADBEEF then 32'h01234567, each stable whenever request=1; done pulses once; frame_cnt=1.
- Three back-to-back beats with tlast on the third -> six four-phase handshakes in order; hsked pulses 3 times; done pulses once after the sixth word; tready is never high outside IDLE.
- Responder never acks with TIMEOUT_CYCLES=16 -> error rises 16 cycles after entering REQ and request goes low; i_clr_err then returns the block to IDLE with tready=1 once ack_s==0.
- acknowledge held high at entry to IDLE -> tready stays 0 until ack_s has been low for SYNC_STAGES cycles.
- Reset asserted while in REQ -> request=0 and busy=0 the next cycle; frame_cnt=0; the next beat is sent from its high word.
- CNT_W=4 with 17 beats -> frame_cnt wraps to 1.

Source files
------------

// File: rtl/paicore_tx_pkg.sv
// Shared types and widths for the PAICORE transmit path.
// State encoding plus word/beat widths used by both directions.
package paicore_tx_pkg;

    localparam int WORD_W = 32;
    localparam int BEAT_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        REQ,
        RELEASE,
        ERROR
    } tx_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop single-bit synchroniser for asynchronous handshake inputs.
// Synchronous active-high reset empties the chain.
module sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/axis_req_ack_32bit_sender.sv
// AXI-Stream 64-bit beats to PAICORE four-phase req/ack, high word first.
// Reports busy, done, sent-beat count and handshake timeout.
module axis_req_ack_32bit_sender
    import paicore_tx_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 32
) (
    input  logic              s_axis_aclk,
    input  logic              s_axis_areset,
    input  logic              s_axis_tvalid,
    input  logic [BEAT_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic              s_axis_hsked,
    output logic [WORD_W-1:0] dout,
    output logic              request,
    input  logic              acknowledge,
    input  logic              i_clr_err,
    output logic              o_tx_busy,
    output logic              o_tx_done,
    output logic              o_tx_error,
    output logic [CNT_W-1:0]  o_frame_cnt
);

    tx_state_e r_state;
    tx_state_e w_next;

    logic              w_ack_s;
    logic              w_hsk;
    logic              w_to_hit;
    logic              w_beat_done;
    logic [WORD_W-1:0] r_lo;
    logic              r_last;
    logic              r_word_sel;
    logic [WORD_W-1:0] r_dout;
    logic              r_request;
    logic              r_tready;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_to_cnt;

    sync_ff #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .i_clk(s_axis_aclk),
        .i_rst(s_axis_areset),
        .i_d  (acknowledge),
        .o_q  (w_ack_s)
    );

    assign w_hsk    = s_axis_tvalid && r_tready;
    assign w_to_hit = (TIMEOUT_CYCLES != 0)
                   && (r_to_cnt == 32'(TIMEOUT_CYCLES));

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_hsk) w_next = SETUP;
            end
            SETUP: begin
                w_next = REQ;
            end
            REQ: begin
                if (w_to_hit)     w_next = ERROR;
                else if (w_ack_s) w_next = RELEASE;
            end
            RELEASE: begin
                if (w_to_hit)      w_next = ERROR;
                else if (!w_ack_s) w_next = r_word_sel ? IDLE : SETUP;
            end
            ERROR: begin
                if (i_clr_err) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_beat_done = (r_state == RELEASE) && (w_next == IDLE);

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            r_lo       <= '0;
            r_last     <= 1'b0;
            r_word_sel <= 1'b0;
            r_dout     <= '0;
            r_request  <= 1'b0;
            r_tready   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_cnt      <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_request <= (w_next == REQ);
            r_busy    <= (w_next != IDLE);
            r_error   <= (w_next == ERROR);
            // ready only once the synchronised ack is quiet
            r_tready  <= (w_next == IDLE) && !w_ack_s;
            r_done    <= w_beat_done && r_last;
            if (w_hsk) begin
                r_lo       <= s_axis_tdata[WORD_W-1:0];
                r_last     <= s_axis_tlast;
                r_word_sel <= 1'b0;
                r_dout     <= s_axis_tdata[BEAT_W-1:WORD_W];
            end
            if (r_state == RELEASE && w_next == SETUP) begin
                r_word_sel <= 1'b1;
                r_dout     <= r_lo;
            end
            if (w_beat_done) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_next != r_state) begin
                r_to_cnt <= '0;
            end else if (r_state == REQ || r_state == RELEASE) begin
                r_to_cnt <= r_to_cnt + 32'd1;
            end
        end
    end

    assign s_axis_tready = r_tready;
    assign s_axis_hsked  = w_hsk;
    assign dout          = r_dout;
    assign request       = r_request;
    assign o_tx_busy     = r_busy;
    assign o_tx_done     = r_done;
    assign o_tx_error    = r_error;
    assign o_frame_cnt   = r_cnt;

endmodule

// File: tb/tb_axis_req_ack_32bit_sender.sv
// Randomised bench: word queue reference model plus a four-phase responder.
// Counts beats, done pulses and handshakes against the expected totals.
module tb_axis_req_ack_32bit_sender;

    localparam int SYNC = 2;
    localparam int TO   = 16;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          areset = 1'b1;
    logic          tvalid = 1'b0;
    logic [63:0]   tdata = '0;
    logic          tlast = 1'b0;
    logic          tready;
    logic          hsked;
    logic [31:0]   dout;
    logic          request;
    logic          acknowledge = 1'b0;
    logic          clr_err = 1'b0;
    logic          busy;
    logic          done;
    logic          error;
    logic [CW-1:0] frame_cnt;

    int n_assert = 0;
    int n_fail = 0;
    int mode = 0;
    int exp_frames = 0;
    int exp_done = 0;
    int exp_hsk = 0;
    int seen_done = 0;
    int seen_hsk = 0;
    logic [31:0] word_q[$];

    always #5 clk = ~clk;

    axis_req_ack_32bit_sender #(
        .SYNC_STAGES(SYNC),
        .TIMEOUT_CYCLES(TO),
        .CNT_W(CW)
    ) dut (
        .s_axis_aclk  (clk),
        .s_axis_areset(areset),
        .s_axis_tvalid(tvalid),
        .s_axis_tdata (tdata),
        .s_axis_tlast (tlast),
        .s_axis_tready(tready),
        .s_axis_hsked (hsked),
        .dout         (dout),
        .request      (request),
        .acknowledge  (acknowledge),
        .i_clr_err    (clr_err),
        .o_tx_busy    (busy),
        .o_tx_done    (done),
        .o_tx_error   (error),
        .o_frame_cnt  (frame_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // monitor: word order, stability under request, ready only when idle
    always @(negedge clk) begin
        if (hsked) seen_hsk++;
        if (done) seen_done++;
        if (tready) check("tready_idle", 64'(busy), 64'd0);
        if (request && !acknowledge) begin
            check("wordq_nonempty", 64'(word_q.size() != 0), 64'd1);
            if (word_q.size() != 0)
                check("dout", 64'(dout), 64'(word_q[0]));
        end
    end

    // PAICORE-side responder
    initial begin
        int d;
        int n;
        forever begin
            @(negedge clk);
            if (request && !acknowledge && mode != 2) begin
                d = (mode == 1) ? 3 : $urandom_range(1, 5);
                repeat (d) @(posedge clk);
                #2;
                if (request) begin
                    acknowledge = 1'b1;
                    if (word_q.size() != 0) void'(word_q.pop_front());
                    n = 0;
                    while (request && n < 200) begin
                        @(negedge clk);
                        n++;
                    end
                    check("req_drop", 64'(request), 64'd0);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    @(posedge clk);
                    #2 acknowledge = 1'b0;
                end
            end
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic l,
                             input bit counted);
        int n;
        @(posedge clk);
        #1;
        tvalid = 1'b1;
        tdata  = d;
        tlast  = l;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tready && n < 400);
        check("accept_to", 64'(tready), 64'd1);
        if (tready) begin
            word_q.push_back(d[63:32]);
            word_q.push_back(d[31:0]);
            exp_hsk++;
            if (counted) begin
                exp_frames++;
                if (l) exp_done++;
            end
        end
        @(posedge clk);
        #1 tvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || word_q.size() != 0) && n < 2000);
        @(negedge clk);
        check("idle_to", 64'(busy), 64'd0);
    endtask

    initial begin
        int k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tready", 64'(tready), 64'd0);
        check("rst_hsked", 64'(hsked), 64'd0);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_request", 64'(request), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_cnt", 64'(frame_cnt), 64'd0);
        @(posedge clk);
        #1 areset = 1'b0;

        mode = 1;
        send_beat(64'hDEAD_BEEF_0123_4567, 1'b1, 1'b1);
        wait_idle();
        check("single_cnt", 64'(frame_cnt), 64'd1);
        check("single_done", 64'(seen_done), 64'd1);

        mode = 0;
        for (int i = 0; i < 3; i++)
            send_beat({$urandom, $urandom}, i == 2, 1'b1);
        wait_idle();
        check("b2b_done", 64'(seen_done), 64'(exp_done));
        check("b2b_hsk", 64'(seen_hsk), 64'(exp_hsk));

        for (int i = 0; i < 13; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send_beat({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1);
        end
        wait_idle();
        check("wrap_cnt", 64'(frame_cnt), 64'(exp_frames % (1 << CW)));
        check("rand_done", 64'(seen_done), 64'(exp_done));

        // responder silent: handshake must time out
        mode = 2;
        send_beat({$urandom, $urandom}, 1'b1, 1'b0);
        k = 0;
        while (!request && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("req_rise", 64'(request), 64'd1);
        k = 0;
        while (request && k < 100) begin
            k++;
            @(negedge clk);
        end
        check("to_len", 64'(k), 64'(TO + 1));
        check("to_error", 64'(error), 64'd1);
        check("to_busy", 64'(busy), 64'd1);
        check("to_tready", 64'(tready), 64'd0);
        word_q.delete();

        // stale acknowledge at IDLE entry keeps tready low
        @(posedge clk);
        #2 acknowledge = 1'b1;
        repeat (5) @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("clr_error", 64'(error), 64'd0);
            check("stale_tready", 64'(tready), 64'd0);
        end
        @(posedge clk);
        #2 acknowledge = 1'b0;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!tready && k < 20);
        check("ack_low_lat", 64'(k), 64'(SYNC + 1));
        check("post_err_busy", 64'(busy), 64'd0);

        // reset while in REQ
        send_beat({$urandom, $urandom}, 1'b1, 1'b0);
        k = 0;
        while (!request && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("req_rise2", 64'(request), 64'd1);
        @(posedge clk);
        #1 areset = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 areset = 1'b0;
        @(negedge clk);
        check("rreq_request", 64'(request), 64'd0);
        check("rreq_busy", 64'(busy), 64'd0);
        check("rreq_cnt", 64'(frame_cnt), 64'd0);
        word_q.delete();
        exp_frames = 0;

        mode = 0;
        send_beat(64'h0123_4567_89AB_CDEF, 1'b1, 1'b1);
        wait_idle();
        check("after_rst_cnt", 64'(frame_cnt), 64'd1);
        check("final_done", 64'(seen_done), 64'(exp_done));
        check("final_hsk", 64'(seen_hsk), 64'(exp_hsk));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
